// File: rtl/if_id_fetch_queue.sv
// IF->ID instruction fetch queue: a DEPTH-entry circular buffer of {PC, NextPC, Instruction}
// that absorbs ID stalls without losing fetched instructions, and empties on control-flow redirect.
module if_id_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [31:0]   PC_if,
  input  logic [31:0]   NextPC_if,
  input  logic [31:0]   Instruction_if,
  output logic          PC_IFWrite,
  input  logic          flush,
  input  logic          ID_stall,
  output logic          valid_id,
  output logic [31:0]   PC_id,
  output logic [31:0]   NextPC_id,
  output logic [31:0]   Instruction_id,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [95:0]   mem_q [DEPTH];
  logic [95:0]   head;
  logic          push;
  logic          pop;

  // Handshake: IF transfers when in_valid & PC_IFWrite; ID takes the head when
  // valid_id & ~ID_stall. Both sides are ignored in a cycle with flush set.
  always_comb begin
    PC_IFWrite = (count_q != FULL_CNT);
    valid_id   = (count_q != '0);
    push       = in_valid & PC_IFWrite & ~flush;
    pop        = valid_id & ~ID_stall & ~flush;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: outputs are masked whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {PC_if, NextPC_if, Instruction_if};
  end

  always_comb begin
    head           = valid_id ? mem_q[rd_ptr_q] : '0;
    PC_id          = head[95:64];
    NextPC_id      = head[63:32];
    Instruction_id = head[31:0];
    count          = count_q;
  end

endmodule
